// File: rtl/psram_rd_check.sv
`default_nettype none
// ==========================================================================
// psram_rd_check : compares PSRAM read bursts against the incrementing
//                  pattern of the traffic generator and keeps error stats.
// Revision 1.0
// ==========================================================================
module psram_rd_check #(
  parameter int BURST_LEN = 32,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 4096,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 init_cable_complete,
  input  logic                 rw_ctrl,
  input  logic                 psram_rd_valid,
  input  logic [DATA_W-1:0]    rd_data,
  input  logic                 clear_err,
  output logic                 chk_done,
  output logic                 check_pass,
  output logic                 check_fail,
  output logic                 timeout_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [15:0]          burst_cnt,
  output logic [11:0]          first_err_idx,
  output logic [DATA_W-1:0]    first_err_data
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_RD, CHECK, REPORT} state_t;

  state_t              state;
  logic                rw_prev;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                first_hit;

  logic                rw_fall, rw_rise;
  logic                beat_err, stray, last_beat, abort, tmo_fire;
  logic [1:0]          err_inc;
  logic                err_any, fail_next;
  logic [ERR_CNT_W:0]  err_sum;
  logic [ERR_CNT_W-1:0] err_sat;
  logic [11:0]         err_idx;

  always_comb begin
    rw_fall   = rw_prev & ~rw_ctrl;
    rw_rise   = ~rw_prev & rw_ctrl;
    beat_err  = (state == CHECK) && psram_rd_valid && (rd_data != DATA_W'(beat_cnt));
    stray     = psram_rd_valid && ((state == WAIT_RD) || (state == REPORT));
    last_beat = (state == CHECK) && psram_rd_valid && (beat_cnt == BEAT_W'(BURST_LEN - 1));
    // a rise on the very beat that completes the burst is not a short burst
    abort     = (state == CHECK) && rw_rise && !last_beat;
    tmo_fire  = (state == CHECK) && !psram_rd_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    err_inc   = 2'(beat_err | stray) + 2'(abort) + 2'(tmo_fire);
    err_any   = (err_inc != 2'd0);
    fail_next = (check_fail && !clear_err) || err_any;
    err_sum   = {1'b0, err_cnt} + (ERR_CNT_W + 1)'(err_inc);
    err_sat   = err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
    err_idx   = stray ? 12'hFFF : 12'(beat_cnt);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state          <= IDLE;
      rw_prev        <= 1'b1;
      beat_cnt       <= '0;
      tmo_cnt        <= '0;
      first_hit      <= 1'b0;
      chk_done       <= 1'b0;
      check_pass     <= 1'b0;
      check_fail     <= 1'b0;
      timeout_err    <= 1'b0;
      err_cnt        <= '0;
      burst_cnt      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else begin
      rw_prev  <= rw_ctrl;
      chk_done <= 1'b0;

      if (clear_err) begin
        err_cnt        <= '0;
        check_fail     <= 1'b0;
        timeout_err    <= 1'b0;
        check_pass     <= 1'b0;
        first_err_idx  <= '0;
        first_err_data <= '0;
        first_hit      <= 1'b0;
      end

      // an error in the clear cycle overrides the clear and becomes the first error
      if (err_any) begin
        err_cnt    <= clear_err ? ERR_CNT_W'(err_inc) : err_sat;
        check_fail <= 1'b1;
        check_pass <= 1'b0;
        if (!first_hit || clear_err) begin
          first_hit      <= 1'b1;
          first_err_idx  <= err_idx;
          first_err_data <= rd_data;
        end
      end

      if (tmo_fire) timeout_err <= 1'b1;

      if (state == REPORT) begin
        burst_cnt  <= burst_cnt + 16'd1;
        check_pass <= !fail_next;
      end

      if (!init_cable_complete) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= WAIT_RD;
          end
          WAIT_RD: begin
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            if (rw_fall) state <= CHECK;
          end
          CHECK: begin
            if (psram_rd_valid) begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
              tmo_cnt  <= '0;
            end else begin
              tmo_cnt  <= tmo_cnt + TMO_W'(1);
            end
            if (last_beat || abort || tmo_fire) begin
              state    <= REPORT;
              chk_done <= 1'b1;
            end
          end
          default: state <= WAIT_RD;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psram_rd_check.sv
`default_nettype none
// ==========================================================================
// tb_psram_rd_check : directed bench with a per-burst result scoreboard.
// Revision 1.0
// ==========================================================================
module tb_psram_rd_check;

  localparam int BURST_LEN = 32;
  localparam int DATA_W    = 16;
  localparam int TIMEOUT   = 64;
  localparam int ERR_CNT_W = 4;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b0;
  logic                 init_cable_complete = 1'b0;
  logic                 rw_ctrl = 1'b1;
  logic                 psram_rd_valid = 1'b0;
  logic [DATA_W-1:0]    rd_data = '0;
  logic                 clear_err = 1'b0;
  logic                 chk_done, check_pass, check_fail, timeout_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [15:0]          burst_cnt;
  logic [11:0]          first_err_idx;
  logic [DATA_W-1:0]    first_err_data;

  typedef struct {
    int err;
    bit fail;
    bit tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  psram_rd_check #(
    .BURST_LEN(BURST_LEN), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_cable_complete(init_cable_complete),
    .rw_ctrl(rw_ctrl), .psram_rd_valid(psram_rd_valid), .rd_data(rd_data),
    .clear_err(clear_err), .chk_done(chk_done), .check_pass(check_pass),
    .check_fail(check_fail), .timeout_err(timeout_err), .err_cnt(err_cnt),
    .burst_cnt(burst_cnt), .first_err_idx(first_err_idx), .first_err_data(first_err_data)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then score any burst report the DUT just raised
  task automatic tick();
    exp_t e;
    @(posedge sys_clk);
    #1;
    if (chk_done) begin
      chk("chk_done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_err_cnt", 32'(err_cnt), 32'(e.err));
        chk("sb_check_fail", 32'(check_fail), 32'(e.fail));
        chk("sb_timeout_err", 32'(timeout_err), 32'(e.tmo));
      end
    end
  endtask

  task automatic write_phase();
    rw_ctrl = 1'b1;
    repeat (3) tick();
  endtask

  task automatic start_read();
    rw_ctrl = 1'b0;
    tick();
  endtask

  task automatic read_beats(input int first, input int n, input int bad_idx,
                            input logic [15:0] bad_val, input int gap);
    for (int k = first; k < first + n; k++) begin
      psram_rd_valid = 1'b1;
      rd_data = (k == bad_idx) ? bad_val : 16'(k);
      tick();
      psram_rd_valid = 1'b0;
      if (k != first + n - 1) for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    chk("rst_flags", {28'd0, chk_done, check_pass, check_fail, timeout_err}, 32'd0);
    sys_rst = 1'b1;
    init_cable_complete = 1'b1;
    tick();

    // three clean bursts
    for (int i = 0; i < 3; i++) begin
      write_phase();
      sb.push_back('{0, 1'b0, 1'b0});
      start_read();
      read_beats(0, BURST_LEN, -1, 16'h0, 0);
      chk("clean_drained", 32'(sb.size()), 32'd0);
      tick();
      chk("clean_burst_cnt", 32'(burst_cnt), 32'(i + 1));
      chk("clean_pass", 32'(check_pass), 32'd1);
    end
    chk("clean_err_cnt", 32'(err_cnt), 32'd0);
    chk("clean_fail", 32'(check_fail), 32'd0);

    // single corrupted beat
    write_phase();
    sb.push_back('{1, 1'b1, 1'b0});
    start_read();
    read_beats(0, 6, 5, 16'h0105, 0);
    chk("corr_err_cnt", 32'(err_cnt), 32'd1);
    chk("corr_idx", 32'(first_err_idx), 32'd5);
    chk("corr_data", 32'(first_err_data), 32'h0105);
    chk("corr_fail", 32'(check_fail), 32'd1);
    chk("corr_pass", 32'(check_pass), 32'd0);
    read_beats(6, BURST_LEN - 6, -1, 16'h0, 0);
    chk("corr_drained", 32'(sb.size()), 32'd0);
    tick();
    chk("corr_burst_cnt", 32'(burst_cnt), 32'd4);
    chk("corr_pass_after", 32'(check_pass), 32'd0);

    // clear, then gapped beats followed by a stall
    do_clear();
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_flags", {29'd0, check_pass, check_fail, timeout_err}, 32'd0);
    chk("clr_idx", 32'(first_err_idx), 32'd0);
    write_phase();
    sb.push_back('{1, 1'b1, 1'b1});
    start_read();
    read_beats(0, 10, -1, 16'h0, 2);
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_yet", 32'(timeout_err), 32'd0);
    tick();
    chk("tmo_done_pulse", 32'(chk_done), 32'd1);
    chk("tmo_drained", 32'(sb.size()), 32'd0);
    tick();
    chk("tmo_burst_cnt", 32'(burst_cnt), 32'd5);

    // early abort after 20 beats, then a stray beat in WAIT_RD
    do_clear();
    write_phase();
    sb.push_back('{1, 1'b1, 1'b0});
    start_read();
    read_beats(0, 20, -1, 16'h0, 0);
    rw_ctrl = 1'b1;
    tick();
    chk("abort_idx", 32'(first_err_idx), 32'd20);
    chk("abort_drained", 32'(sb.size()), 32'd0);
    tick();
    chk("abort_burst_cnt", 32'(burst_cnt), 32'd6);
    psram_rd_valid = 1'b1;
    rd_data = 16'h0;
    tick();
    psram_rd_valid = 1'b0;
    chk("stray_err_cnt", 32'(err_cnt), 32'd2);
    chk("stray_idx_kept", 32'(first_err_idx), 32'd20);

    // saturation of a 4-bit counter
    do_clear();
    write_phase();
    sb.push_back('{15, 1'b1, 1'b0});
    start_read();
    for (int k = 0; k < 20; k++) begin
      psram_rd_valid = 1'b1;
      rd_data = ~16'(k);
      tick();
    end
    psram_rd_valid = 1'b0;
    chk("sat_err_cnt", 32'(err_cnt), 32'd15);
    chk("sat_idx", 32'(first_err_idx), 32'd0);
    read_beats(20, BURST_LEN - 20, -1, 16'h0, 0);
    chk("sat_drained", 32'(sb.size()), 32'd0);
    tick();

    // clear coincident with a mismatch: the error wins
    write_phase();
    sb.push_back('{1, 1'b1, 1'b0});
    start_read();
    read_beats(0, 3, -1, 16'h0, 0);
    clear_err = 1'b1;
    psram_rd_valid = 1'b1;
    rd_data = 16'hBEEF;
    tick();
    clear_err = 1'b0;
    psram_rd_valid = 1'b0;
    chk("clrerr_err_cnt", 32'(err_cnt), 32'd1);
    chk("clrerr_idx", 32'(first_err_idx), 32'd3);
    chk("clrerr_data", 32'(first_err_data), 32'hBEEF);
    chk("clrerr_fail", 32'(check_fail), 32'd1);
    read_beats(4, BURST_LEN - 4, -1, 16'h0, 0);
    chk("clrerr_drained", 32'(sb.size()), 32'd0);
    tick();

    // asynchronous reset in the middle of a burst
    write_phase();
    start_read();
    read_beats(0, 12, -1, 16'h0, 0);
    #2 sys_rst = 1'b0;
    #1;
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_burst_cnt", 32'(burst_cnt), 32'd0);
    chk("arst_flags", {28'd0, chk_done, check_pass, check_fail, timeout_err}, 32'd0);
    chk("arst_first", {4'd0, first_err_idx, first_err_data}, 32'd0);
    #2 sys_rst = 1'b1;
    tick();
    read_beats(12, 3, -1, 16'h0, 0);
    chk("post_rst_stray_cnt", 32'(err_cnt), 32'd3);
    chk("post_rst_stray_idx", 32'(first_err_idx), 32'hFFF);
    chk("post_rst_stray_data", 32'(first_err_data), 32'h000C);
    chk("post_rst_burst_cnt", 32'(burst_cnt), 32'd0);
    do_clear();
    write_phase();
    sb.push_back('{0, 1'b0, 1'b0});
    start_read();
    read_beats(0, BURST_LEN, -1, 16'h0, 0);
    chk("final_drained", 32'(sb.size()), 32'd0);
    tick();
    chk("final_burst_cnt", 32'(burst_cnt), 32'd1);
    chk("final_pass", 32'(check_pass), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psram_rd_check.md
Name: psram_rd_check

Overview:
- Read-data checker directly downstream of the PSRAM test traffic generator.
- Consumes the read beats returned by the PSRAM controller and compares each one against the incrementing pattern written by the generator.
- Accumulates error statistics and reports pass/fail per burst and sticky overall.
- Drives board status LEDs and debug probes.

Parameters:
BURST_LEN, 32, beats per read burst; must equal the generator's burst_len
DATA_W, 16, read data width
TIMEOUT, 4096, max cycles allowed between read beats while checking
ERR_CNT_W, 16, width of error counter

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  asynchronous active-low reset
init_cable_complete  input  1  PSRAM calibration done; checker idle until high
rw_ctrl  input  1  generator phase flag: 1 = write phase, 0 = read phase
psram_rd_valid  input  1  read beat valid from controller
rd_data  input  DATA_W  read beat data, qualified by psram_rd_valid
clear_err  input  1  synchronous clear of error statistics
chk_done  output  1  one-cycle pulse per completed or aborted burst check
check_pass  output  1  high once ≥1 burst has completed with zero errors since reset/clear
check_fail  output  1  sticky error flag
timeout_err  output  1  sticky: beat gap exceeded TIMEOUT
err_cnt  output  ERR_CNT_W  total errors, saturating
burst_cnt  output  16  bursts checked, wraps at 0xFFFF→0
first_err_idx  output  12  beat index of the first error
first_err_data  output  DATA_W  rd_data of the first error

Behaviour:
- Reset (sys_rst low, async): state IDLE; all outputs 0; beat counter 0; timeout counter 0; internal rw_ctrl delay register 1.
- Expected data for beat k (0-based within a burst) = k zero-extended to DATA_W.
- States and transitions:
  - IDLE: go to WAIT_RD when init_cable_complete=1.
  - WAIT_RD: go to CHECK on rw_ctrl falling edge (registered prev=1, current=0). Beat counter and timeout counter cleared on entry.
  - CHECK: each cycle with psram_rd_valid=1, compare rd_data to the expected value, then increment the beat counter and clear the timeout counter. The cycle the counter reaches BURST_LEN, go to REPORT.
  - REPORT: lasts one cycle; then go to WAIT_RD.
- Mismatch: on the same edge the beat is sampled, err_cnt += 1 (saturates at all-ones) and check_fail is set. If this is the first error since reset/clear, first_err_idx and first_err_data are captured.
- Stray beat: psram_rd_valid=1 in WAIT_RD or REPORT counts as one error; its idx is captured as 0xFFF.
- Timeout: in CHECK, the timeout counter increments on cycles with no valid beat. When it reaches TIMEOUT, set timeout_err, increment err_cnt, set check_fail, and go to REPORT.
- Early abort: rw_ctrl rising to 1 while in CHECK before BURST_LEN beats counts as one error (short burst); go to REPORT. A valid beat in that same cycle is still compared.
- REPORT:
  - chk_done=1 for exactly this cycle; burst_cnt += 1.
  - check_pass set if check_fail=0 (including errors from the final beat), otherwise cleared.
  - check_pass clears whenever check_fail sets.
- clear_err=1:
  - Clears err_cnt, check_fail, timeout_err, check_pass, first_err_idx and first_err_data, and re-arms first-error capture.
  - Does not affect the state, beat counter or burst_cnt.
  - If an error occurs in the same cycle, the error wins: err_cnt=1, check_fail=1, and that error is captured as first.
- init_cable_complete falling returns the FSM to IDLE from any state; statistics are held.
- Reset mid-burst: all state is lost. After release, the checker waits for the next rw_ctrl falling edge; a partially-read burst is not checked.

Test Plan:
- Clean loop: 3 write/read cycles with rd_data=0..31 on consecutive valid beats → 3 chk_done pulses, burst_cnt=3, err_cnt=0, check_pass=1, check_fail=0.
- Single corruption: burst 1, beat 5 returns 0x0105 → err_cnt=1 on the same edge, first_err_idx=5, first_err_data=0x0105, check_fail=1, check_pass=0 from then on.
- Gapped beats then stall: 10 beats spaced 3 cycles apart, then none for TIMEOUT cycles → timeout_err=1, err_cnt=1, chk_done pulses once, FSM returns to WAIT_RD.
- Early abort: rw_ctrl rises after 20 beats → err_cnt=1, chk_done pulse, burst_cnt+1. A stray valid in WAIT_RD → err_cnt=2, first_err_idx unchanged at 20.
- Saturation and clear: ERR_CNT_W=4, 20 mismatches → err_cnt=15. clear_err coincident with a mismatch → err_cnt=1 and first_err recaptured.
- Async reset asserted mid-CHECK at beat 12 → all outputs 0 immediately. After release, beats without a rw_ctrl falling edge count as stray errors, and the next full read burst checks clean.
